// File: rtl/regbank_pkg.sv
// regbank_pkg: shared definitions for the 4x8-bit register bank and its
// initiator-side access sequencer.
//   DW, AW          : bank word width and register address width
//   RB_READ/RB_WRITE: encoding of the bank rw pin
//   seq_state_t     : sequencer FSM states
package regbank_pkg;

  localparam int DW = 8;
  localparam int AW = 2;

  localparam logic RB_READ  = 1'b1;
  localparam logic RB_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_A     = 3'd1,
    ST_RD_B     = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_WAIT_RES = 3'd4,
    ST_WB       = 3'd5
  } seq_state_t;

endpackage

// File: rtl/regbank_sequencer.sv
// regbank_sequencer: initiator-side access controller for the register bank.
// Accepts one operation at a time, reads its source operand(s) over the
// bank's single shared port, presents them to the datapath, waits for the
// result and drives a single write-back cycle.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        operation request handshake
//   req_src_a, req_src_b       source registers
//   req_two_src                1 = src_b is read as well
//   req_wb_en, req_dst         write-back enable and destination
//   opnd_valid/opnd_ready, opa, opb   operands to the datapath
//   res_valid/res_ready, res_data     result from the datapath
//   rb_r_add, rb_w_add, rb_rw, rb_wdata, rb_rdata   bank port
//
// Build option:
//   REGBANK_SEQ_SAMESRC_EN  when defined, a two-source request whose sources
//                           are equal skips the second bank read and loads
//                           opb with the same word as opa.
module regbank_sequencer #(
  parameter int DW = regbank_pkg::DW,
  parameter int AW = regbank_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_src_a,
  input  logic [AW-1:0] req_src_b,
  input  logic          req_two_src,
  input  logic          req_wb_en,
  input  logic [AW-1:0] req_dst,
  output logic          opnd_valid,
  input  logic          opnd_ready,
  output logic [DW-1:0] opa,
  output logic [DW-1:0] opb,
  input  logic          res_valid,
  output logic          res_ready,
  input  logic [DW-1:0] res_data,
  output logic [AW-1:0] rb_r_add,
  output logic [AW-1:0] rb_w_add,
  output logic          rb_rw,
  output logic [DW-1:0] rb_wdata,
  input  logic [DW-1:0] rb_rdata
);

  import regbank_pkg::*;

  seq_state_t    state_q;
  logic [AW-1:0] src_a_q;
  logic [AW-1:0] src_b_q;
  logic          two_src_q;
  logic          wb_en_q;
  logic [AW-1:0] dst_q;
  logic          same_src;

`ifdef REGBANK_SEQ_SAMESRC_EN
  assign same_src = (src_b_q == src_a_q);
`else
  assign same_src = 1'b0;
`endif

  // Handshake readies decode straight from the state; gating with rst_n keeps
  // them low for the whole reset period.
  assign req_ready = rst_n && (state_q == ST_IDLE);
  assign res_ready = rst_n && (state_q == ST_WAIT_RES);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // rb_rw returns to read at this edge, ahead of the bank's negedge
      // sample, so an aborted write-back never commits.
      state_q    <= ST_IDLE;
      src_a_q    <= '0;
      src_b_q    <= '0;
      two_src_q  <= 1'b0;
      wb_en_q    <= 1'b0;
      dst_q      <= '0;
      opnd_valid <= 1'b0;
      opa        <= '0;
      opb        <= '0;
      rb_r_add   <= '0;
      rb_w_add   <= '0;
      rb_rw      <= RB_READ;
      rb_wdata   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            src_a_q   <= req_src_a;
            src_b_q   <= req_src_b;
            two_src_q <= req_two_src;
            wb_en_q   <= req_wb_en;
            dst_q     <= req_dst;
            rb_r_add  <= req_src_a;
            rb_rw     <= RB_READ;
            state_q   <= ST_RD_A;
          end
        end
        ST_RD_A: begin
          opa <= rb_rdata;
          if (two_src_q && !same_src) begin
            rb_r_add <= src_b_q;
            state_q  <= ST_RD_B;
          end else begin
            // Reaching here with two_src set means the sources matched, so
            // the word just read serves both operands.
            opb        <= two_src_q ? rb_rdata : '0;
            opnd_valid <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_RD_B: begin
          opb        <= rb_rdata;
          opnd_valid <= 1'b1;
          state_q    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (opnd_ready) begin
            opnd_valid <= 1'b0;
            state_q    <= wb_en_q ? ST_WAIT_RES : ST_IDLE;
          end
        end
        ST_WAIT_RES: begin
          if (res_valid) begin
            rb_wdata <= res_data;
            rb_w_add <= dst_q;
            rb_rw    <= RB_WRITE;
            state_q  <= ST_WB;
          end
        end
        ST_WB: begin
          rb_rw   <= RB_READ;
          state_q <= ST_IDLE;
        end
        default: begin
          rb_rw   <= RB_READ;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_sequencer.sv
module tb_regbank_sequencer;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_src_a = '0;
  logic [AW-1:0] req_src_b = '0;
  logic          req_two_src = 1'b0;
  logic          req_wb_en = 1'b0;
  logic [AW-1:0] req_dst = '0;
  logic          opnd_valid;
  logic          opnd_ready = 1'b0;
  logic [DW-1:0] opa, opb;
  logic          res_valid = 1'b0;
  logic          res_ready;
  logic [DW-1:0] res_data = '0;
  logic [AW-1:0] rb_r_add, rb_w_add;
  logic          rb_rw;
  logic [DW-1:0] rb_wdata;
  logic [DW-1:0] rb_rdata = '0;

  int checks = 0;
  int failures = 0;
  int write_cnt = 0;

  // Bank contents (the "hardware" bank) and the bench's own expectation.
  logic [DW-1:0] mem [4];
  logic [DW-1:0] ref_mem [4];

  regbank_sequencer #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src_a(req_src_a), .req_src_b(req_src_b),
    .req_two_src(req_two_src), .req_wb_en(req_wb_en), .req_dst(req_dst),
    .opnd_valid(opnd_valid), .opnd_ready(opnd_ready),
    .opa(opa), .opb(opb),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .rb_r_add(rb_r_add), .rb_w_add(rb_w_add), .rb_rw(rb_rw),
    .rb_wdata(rb_wdata), .rb_rdata(rb_rdata)
  );

  always #5 clk = ~clk;

  // Bank model: samples on the falling edge; read data is seen at the next
  // rising edge, a write commits at this falling edge.
  always @(negedge clk) begin
    rb_rdata <= mem[rb_r_add];
    if (rb_rw === 1'b0) begin
      mem[rb_w_add] <= rb_wdata;
      write_cnt = write_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request and wait for the operands; checks latency and values.
  task automatic start_op(input int a, input int b, input bit two, input bit wb, input int dst);
    int lat;
    int exp_lat;
    logic [DW-1:0] exp_a, exp_b;
    exp_a = ref_mem[a];
    exp_b = two ? ref_mem[b] : '0;
    exp_lat = two ? 2 : 1;
`ifdef REGBANK_SEQ_SAMESRC_EN
    if (two && a == b) exp_lat = 1;
`endif
    check_eq("req_ready_idle", req_ready, 1);
    req_src_a = a[AW-1:0]; req_src_b = b[AW-1:0];
    req_two_src = two; req_wb_en = wb; req_dst = dst[AW-1:0];
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (opnd_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    check_eq("opnd_latency", lat, exp_lat);
    check_eq("opa", opa, exp_a);
    check_eq("opb", opb, exp_b);
  endtask

  // Hold operands for 'hold' cycles (with a stray res_valid), then hand off.
  task automatic issue(input int hold);
    logic [DW-1:0] a0, b0;
    a0 = opa; b0 = opb;
    for (int i = 0; i < hold; i++) begin
      res_valid = 1'b1;
      res_data  = 8'hEE;
      #1;
      check_eq("res_ready_in_issue", res_ready, 0);
      tick();
      check_eq("opnd_valid_held", opnd_valid, 1);
      check_eq("opa_stable", opa, a0);
      check_eq("opb_stable", opb, b0);
    end
    res_valid = 1'b0;
    opnd_ready = 1'b1;
    tick();
    opnd_ready = 1'b0;
    check_eq("opnd_valid_drop", opnd_valid, 0);
  endtask

  // Deliver the result and verify the single write-back cycle.
  task automatic write_back(input int dst, input logic [DW-1:0] res, input int gap, input bit poke_req);
    int w0;
    check_eq("res_ready_wait", res_ready, 1);
    for (int i = 0; i < gap; i++) begin
      if (poke_req) begin
        req_valid = 1'b1;
        req_src_a = AW'($urandom_range(0, 3));
        #1;
        check_eq("req_ready_in_wait", req_ready, 0);
      end
      tick();
    end
    w0 = write_cnt;
    res_valid = 1'b1;
    res_data  = res;
    tick();
    res_valid = 1'b0;
    check_eq("wb_rw", rb_rw, 0);
    check_eq("wb_w_add", rb_w_add, dst);
    check_eq("wb_wdata", rb_wdata, res);
    check_eq("req_ready_in_wb", req_ready, 0);
    req_valid = 1'b0;
    tick();
    ref_mem[dst] = res;
    check_eq("rw_after_wb", rb_rw, 1);
    check_eq("req_ready_after_wb", req_ready, 1);
    check_eq("write_count", write_cnt - w0, 1);
    check_eq("bank_dst", mem[dst], ref_mem[dst]);
  endtask

  task automatic run_op(input int a, input int b, input bit two, input bit wb, input int dst,
                        input logic [DW-1:0] res, input int hold, input int gap, input bit poke);
    int w0;
    w0 = write_cnt;
    start_op(a, b, two, wb, dst);
    issue(hold);
    if (wb) write_back(dst, res, gap, poke);
    else begin
      check_eq("req_ready_no_wb", req_ready, 1);
      check_eq("no_write", write_cnt - w0, 0);
    end
    for (int r = 0; r < 4; r++) check_eq("bank_contents", mem[r], ref_mem[r]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=0 expected=1");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    mem[0] = 8'h9B; mem[1] = 8'h3C; mem[2] = 8'hA5; mem[3] = 8'h11;
    for (int r = 0; r < 4; r++) ref_mem[r] = mem[r];

    // Reset held for three cycles.
    rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_rb_rw", rb_rw, 1);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_res_ready", res_ready, 0);
    check_eq("rst_opnd_valid", opnd_valid, 0);
    check_eq("rst_opa", opa, 0);
    check_eq("rst_wdata", rb_wdata, 0);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_req_ready", req_ready, 1);

    // Directed: two-source read, no write-back.
    run_op(1, 2, 1'b1, 1'b0, 0, 8'h00, 0, 0, 1'b0);
    // Directed: one-source, write-back 0x7E to R3 with 4 stall cycles.
    run_op(0, 0, 1'b0, 1'b1, 3, 8'h7E, 4, 2, 1'b1);
    // Put 0x55 in R2, then read it as both sources.
    run_op(1, 0, 1'b0, 1'b1, 2, 8'h55, 0, 0, 1'b0);
    run_op(2, 2, 1'b1, 1'b0, 0, 8'h00, 1, 0, 1'b0);
    // Destination equal to a source: operands still see the old value.
    run_op(3, 1, 1'b1, 1'b1, 3, 8'hC3, 0, 1, 1'b0);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      run_op($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $urandom_range(0, 3), 8'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset at the edge where write-back would begin: nothing is written.
    start_op(0, 1, 1'b1, 1'b1, 3);
    issue(0);
    w0 = write_cnt;
    res_valid = 1'b1;
    res_data  = ~ref_mem[3];
    rst_n = 1'b0;
    tick();
    res_valid = 1'b0;
    check_eq("abort_rb_rw", rb_rw, 1);
    check_eq("abort_req_ready", req_ready, 0);
    tick();
    check_eq("abort_no_write", write_cnt - w0, 0);
    check_eq("abort_r3", mem[3], ref_mem[3]);
    check_eq("abort_opnd_valid", opnd_valid, 0);
    rst_n = 1'b1;
    #1;
    check_eq("abort_idle", req_ready, 1);
    run_op(3, 0, 1'b0, 1'b0, 0, 8'h00, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
